// File: rtl/conv_mac_scheduler_if.sv
// Stream interface for conv_mac_scheduler: the pixel/weight input stream
// and the dot-product result stream, each with a valid/ready handshake.
interface conv_mac_scheduler_if #(
  parameter int ACC_W = 20
);
  logic             in_valid;
  logic             in_ready;
  logic [7:0]       in_pixel;
  logic [7:0]       in_weight;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_sum;

  modport master (
    output in_valid, in_pixel, in_weight, out_ready,
    input  in_ready, out_valid, out_sum
  );

  modport slave (
    input  in_valid, in_pixel, in_weight, out_ready,
    output in_ready, out_valid, out_sum
  );
endinterface

// File: rtl/conv_mac_scheduler.sv
// Buffers one convolution window of pixel/weight pairs, then time-shares one
// external 8x8 multiplier to accumulate the dot product and hands it downstream.
module conv_mac_scheduler #(
  parameter int TAPS  = 9,
  parameter int ACC_W = 20
) (
  input  logic                 clk,
  input  logic                 rst,
  conv_mac_scheduler_if.slave  bus,
  output logic [7:0]           mul_a,
  output logic [7:0]           mul_b,
  input  logic [15:0]          mul_c,
  output logic                 busy
);

  localparam int IDX_W = (TAPS > 1) ? $clog2(TAPS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TAPS - 1);

  typedef enum logic [1:0] {
    S_LOAD,
    S_MAC,
    S_DRAIN,
    S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] wr_idx_q, wr_idx_d;
  logic [IDX_W-1:0] rd_idx_q, rd_idx_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [15:0]      prod_q, prod_d;
  logic             prod_v_q, prod_v_d;

  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic             busy_q, busy_d;
  logic [7:0]       mul_a_q, mul_a_d;
  logic [7:0]       mul_b_q, mul_b_d;

  logic [7:0]       pix_buf_q [TAPS];
  logic [7:0]       wt_buf_q  [TAPS];
  logic             buf_we;

  logic [ACC_W-1:0] prod_ext;
  assign prod_ext = {{(ACC_W-16){1'b0}}, prod_q};

  always_comb begin
    state_d  = state_q;
    wr_idx_d = wr_idx_q;
    rd_idx_d = rd_idx_q;
    acc_d    = acc_q;
    prod_d   = prod_q;
    prod_v_d = prod_v_q;
    buf_we   = 1'b0;

    case (state_q)
      S_LOAD: begin
        if (bus.in_valid) begin
          buf_we = 1'b1;
          if (wr_idx_q == LAST_IDX) begin
            wr_idx_d = '0;
            state_d  = S_MAC;
            rd_idx_d = '0;
            acc_d    = '0;
            prod_v_d = 1'b0;
          end else begin
            wr_idx_d = wr_idx_q + IDX_W'(1);
          end
        end
      end
      S_MAC: begin
        // The product registered on the previous edge is folded in while
        // the multiplier works on the current tap.
        prod_d   = mul_c;
        prod_v_d = 1'b1;
        if (prod_v_q) acc_d = acc_q + prod_ext;
        if (rd_idx_q == LAST_IDX) begin
          rd_idx_d = '0;
          state_d  = S_DRAIN;
        end else begin
          rd_idx_d = rd_idx_q + IDX_W'(1);
        end
      end
      S_DRAIN: begin
        acc_d    = acc_q + prod_ext;
        prod_v_d = 1'b0;
        state_d  = S_DONE;
      end
      S_DONE: begin
        if (bus.out_ready) begin
          state_d  = S_LOAD;
          wr_idx_d = '0;
        end
      end
      default: state_d = S_LOAD;
    endcase
  end

  // Outputs are registered from the next state so they line up with state_q.
  // The operand for the next MAC cycle is read from the buffer ahead of time;
  // on LOAD->MAC the slot being written is the last one, never slot 0.
  always_comb begin
    in_ready_d  = (state_d == S_LOAD);
    out_valid_d = (state_d == S_DONE);
    busy_d      = (state_d != S_LOAD);
    mul_a_d     = '0;
    mul_b_d     = '0;
    if (state_d == S_MAC) begin
      mul_a_d = pix_buf_q[rd_idx_d];
      mul_b_d = wt_buf_q[rd_idx_d];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_LOAD;
      wr_idx_q    <= '0;
      rd_idx_q    <= '0;
      acc_q       <= '0;
      prod_q      <= '0;
      prod_v_q    <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
    end else begin
      state_q     <= state_d;
      wr_idx_q    <= wr_idx_d;
      rd_idx_q    <= rd_idx_d;
      acc_q       <= acc_d;
      prod_q      <= prod_d;
      prod_v_q    <= prod_v_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      mul_a_q     <= mul_a_d;
      mul_b_q     <= mul_b_d;
    end
  end

  // Window storage carries no reset; stale contents are always overwritten
  // before the next MAC phase reads them.
  always_ff @(posedge clk) begin
    if (!rst && buf_we) begin
      pix_buf_q[wr_idx_q] <= bus.in_pixel;
      wt_buf_q[wr_idx_q]  <= bus.in_weight;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_sum   = acc_q;
  assign mul_a         = mul_a_q;
  assign mul_b         = mul_b_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_conv_mac_scheduler.sv
// Scoreboard bench for conv_mac_scheduler: windows are driven by a task, the
// expected dot product is queued, and a monitor checks every result handshake.
module tb_conv_mac_scheduler;
  localparam int TAPS  = 9;
  localparam int ACC_W = 20;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  mul_a, mul_b;
  logic [15:0] mul_c;
  logic        busy;

  conv_mac_scheduler_if #(.ACC_W(ACC_W)) bus ();

  conv_mac_scheduler #(.TAPS(TAPS), .ACC_W(ACC_W)) dut (
    .clk   (clk),
    .rst   (rst),
    .bus   (bus),
    .mul_a (mul_a),
    .mul_b (mul_b),
    .mul_c (mul_c),
    .busy  (busy)
  );

  // Behavioural stand-in for the external combinational multiplier.
  assign mul_c = 16'(mul_a) * 16'(mul_b);

  always #5 clk = ~clk;

  int          tests = 0;
  int          fails = 0;
  int unsigned cyc   = 0;
  bit          rnd_rdy = 1'b0;

  int unsigned exp_sum [$];
  int unsigned exp_e0  [$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int unsigned dot(input logic [7:0] p [TAPS], input logic [7:0] w [TAPS]);
    longint unsigned s = 0;
    for (int k = 0; k < TAPS; k++) s += longint'(p[k]) * longint'(w[k]);
    return int'(s % (64'd1 << ACC_W));
  endfunction

  task automatic tick;
    @(negedge clk);
  endtask

  // Monitor: result-stream checks, sampled between edges after drivers settle.
  initial begin : monitor
    bit vprev = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      if (rst) begin
        vprev = 1'b0;
      end else begin
        if (bus.out_valid && !vprev) begin
          if (exp_e0.size() == 0) chk("unexpected_valid", 1, 0);
          else chk("latency", cyc - exp_e0.pop_front(), TAPS + 1);
        end
        if (bus.out_valid && bus.out_ready) begin
          if (exp_sum.size() == 0) chk("unexpected_result", 1, 0);
          else chk("out_sum", 32'(bus.out_sum), exp_sum.pop_front());
        end
        vprev = bus.out_valid && !bus.out_ready;
      end
    end
  end

  always @(negedge clk) if (rnd_rdy) bus.out_ready = 1'($urandom_range(0, 1));

  // Entered and left on a negedge; a beat seen with in_ready high at a negedge
  // is taken at the following posedge.
  task automatic send_window(input logic [7:0] p [TAPS], input logic [7:0] w [TAPS],
                             input int gap_k, input int gap_n, input bit rnd_gap);
    int n;
    int t;
    for (int k = 0; k < TAPS; k++) begin
      n = rnd_gap ? (($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0)
                  : ((k == gap_k) ? gap_n : 0);
      for (int g = 0; g < n; g++) begin
        bus.in_valid = 1'b0;
        if (!rnd_gap) chk("in_ready_gap", 32'(bus.in_ready), 1);
        tick();
      end
      bus.in_valid  = 1'b1;
      bus.in_pixel  = p[k];
      bus.in_weight = w[k];
      t = 0;
      while (!bus.in_ready && t < 200) begin
        tick();
        t++;
      end
      if (t >= 200) chk("in_ready_timeout", 0, 1);
      if (!rnd_gap && k > 0) chk("in_ready_load", 32'(bus.in_ready), 1);
      if (k == TAPS - 1) begin
        exp_sum.push_back(dot(p, w));
        exp_e0.push_back(cyc + 1);
      end
      tick();
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_valid;
    int t = 0;
    while (!bus.out_valid && t < 100) begin
      tick();
      t++;
    end
    if (t >= 100) chk("out_valid_timeout", 0, 1);
  endtask

  task automatic chk_reset;
    chk("rst_in_ready", 32'(bus.in_ready), 1);
    chk("rst_out_valid", 32'(bus.out_valid), 0);
    chk("rst_out_sum", 32'(bus.out_sum), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_mul_a", 32'(mul_a), 0);
    chk("rst_mul_b", 32'(mul_b), 0);
  endtask

  logic [7:0] p [TAPS];
  logic [7:0] w [TAPS];

  initial begin : main
    int t;
    bus.in_valid  = 1'b0;
    bus.in_pixel  = '0;
    bus.in_weight = '0;
    bus.out_ready = 1'b1;
    repeat (3) tick();
    chk_reset();
    rst = 1'b0;
    tick();

    for (int k = 0; k < TAPS; k++) begin p[k] = 8'd1; w[k] = 8'd1; end
    send_window(p, w, -1, 0, 1'b0);
    wait_valid();
    chk("ones_sum", 32'(bus.out_sum), 9);
    tick();

    for (int k = 0; k < TAPS; k++) begin p[k] = 8'd255; w[k] = 8'd255; end
    send_window(p, w, -1, 0, 1'b0);
    wait_valid();
    chk("max_sum", 32'(bus.out_sum), 585225);
    tick();

    for (int k = 0; k < TAPS; k++) begin p[k] = 8'(k + 1); w[k] = 8'(TAPS - k); end
    send_window(p, w, 4, 3, 1'b0);
    wait_valid();
    chk("ramp_sum", 32'(bus.out_sum), 165);
    tick();

    // Downstream stall in DONE.
    bus.out_ready = 1'b0;
    for (int k = 0; k < TAPS; k++) begin p[k] = 8'(k); w[k] = 8'(k); end
    send_window(p, w, -1, 0, 1'b0);
    wait_valid();
    for (int i = 0; i < 5; i++) begin
      chk("stall_valid", 32'(bus.out_valid), 1);
      chk("stall_sum", 32'(bus.out_sum), 204);
      chk("stall_in_ready", 32'(bus.in_ready), 0);
      chk("stall_mul_a", 32'(mul_a), 0);
      chk("stall_mul_b", 32'(mul_b), 0);
      tick();
    end
    bus.out_ready = 1'b1;
    tick();
    chk("release_in_ready", 32'(bus.in_ready), 1);
    chk("release_out_valid", 32'(bus.out_valid), 0);

    // Abort a window mid-MAC.
    for (int k = 0; k < TAPS; k++) begin p[k] = 8'(k + 3); w[k] = 8'(2 * k + 1); end
    send_window(p, w, -1, 0, 1'b0);
    repeat (4) tick();
    chk("mac_busy", 32'(busy), 1);
    chk("mac_mul_a", 32'(mul_a), 32'(p[4]));
    chk("mac_mul_b", 32'(mul_b), 32'(w[4]));
    rst = 1'b1;
    exp_sum.delete();
    exp_e0.delete();
    tick();
    rst = 1'b0;
    chk_reset();

    for (int k = 0; k < TAPS; k++) begin p[k] = 8'd2; w[k] = 8'd3; end
    send_window(p, w, -1, 0, 1'b0);
    wait_valid();
    chk("post_rst_sum", 32'(bus.out_sum), 54);
    tick();

    // Back-to-back windows; the driver holds the first beat through DONE.
    for (int k = 0; k < TAPS; k++) begin p[k] = 8'(k); w[k] = 8'd1; end
    send_window(p, w, -1, 0, 1'b0);
    for (int k = 0; k < TAPS; k++) begin p[k] = 8'd10; w[k] = 8'(k); end
    send_window(p, w, -1, 0, 1'b0);

    // Randomized windows, gaps and downstream backpressure.
    rnd_rdy = 1'b1;
    for (int n = 0; n < 20; n++) begin
      for (int k = 0; k < TAPS; k++) begin
        p[k] = 8'($urandom_range(0, 255));
        w[k] = 8'($urandom_range(0, 255));
      end
      send_window(p, w, -1, 0, 1'b1);
    end
    t = 0;
    while (exp_sum.size() > 0 && t < 2000) begin
      tick();
      t++;
    end
    rnd_rdy = 1'b0;
    bus.out_ready = 1'b1;
    chk("drain_pending", 32'(exp_sum.size()), 0);
    repeat (3) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
